// File: rtl/if_fetch.sv
`default_nettype none
// ============================================================================
// Module   : if_fetch
// Brief    : RV32I instruction-fetch stage; assembles each instruction from
//            four byte reads on a shared 8-bit port and hands {pc, inst} to
//            the IF/ID register over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module if_fetch #(
    parameter int                 ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jump_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              mem_grant_i,
    input  logic [7:0]        mem_din_i,
    output logic [ADDR_W-1:0] mem_a_o,
    output logic              mem_rd_o,
    input  logic              id_ready_i,
    output logic              if_valid_o,
    output logic [ADDR_W-1:0] if_pc_o,
    output logic [31:0]       if_inst_o
);

    typedef enum logic [1:0] {
        S_ISSUE = 2'd0,
        S_DRAIN = 2'd1,
        S_VALID = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_pc;
    logic [1:0]        r_issue_idx;
    logic              r_pending;
    logic [1:0]        r_pend_idx;
    logic [31:0]       r_inst_buf;
    logic              r_valid;
    logic [ADDR_W-1:0] r_if_pc;
    logic [31:0]       r_if_inst;

    logic              w_issue_go;
    logic              w_cap_last;
    logic              w_accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_ISSUE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue_go  = (r_state == S_ISSUE) && mem_grant_i;
        w_cap_last  = r_pending && (r_pend_idx == 2'd3);
        w_accept    = r_valid && id_ready_i;
        case (r_state)
            S_ISSUE: if (w_issue_go && (r_issue_idx == 2'd3)) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_cap_last) w_state_nxt = S_VALID;
            S_VALID: if (w_accept) w_state_nxt = S_ISSUE;
            default: w_state_nxt = S_ISSUE;
        endcase
        if (jump_i) begin
            w_state_nxt = S_ISSUE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= RESET_PC;
            r_issue_idx <= 2'd0;
            r_pending   <= 1'b0;
            r_pend_idx  <= 2'd0;
            r_inst_buf  <= 32'd0;
            r_valid     <= 1'b0;
            r_if_pc     <= '0;
            r_if_inst   <= 32'd0;
        end else if (jump_i) begin
            // Redirect drops any in-flight byte, including one granted now.
            r_pc        <= jump_addr_i;
            r_issue_idx <= 2'd0;
            r_pending   <= 1'b0;
            r_valid     <= 1'b0;
        end else begin
            if (r_pending) begin
                r_inst_buf[{r_pend_idx, 3'b000} +: 8] <= mem_din_i;
            end
            r_pending <= w_issue_go;
            if (w_issue_go) begin
                r_pend_idx  <= r_issue_idx;
                r_issue_idx <= r_issue_idx + 2'd1;
            end
            if ((r_state == S_DRAIN) && w_cap_last) begin
                r_if_inst <= {mem_din_i, r_inst_buf[23:0]};
                r_if_pc   <= r_pc;
                r_valid   <= 1'b1;
            end
            if ((r_state == S_VALID) && w_accept) begin
                r_pc        <= r_pc + ADDR_W'(4);
                r_issue_idx <= 2'd0;
                r_valid     <= 1'b0;
            end
        end
    end

    assign mem_rd_o   = (r_state == S_ISSUE) && !rst;
    assign mem_a_o    = rst ? RESET_PC : (r_pc + ADDR_W'(r_issue_idx));
    assign if_valid_o = r_valid;
    assign if_pc_o    = r_if_pc;
    assign if_inst_o  = r_if_inst;

endmodule
`default_nettype wire

// File: tb/tb_if_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_fetch
// Brief    : Self-checking bench for if_fetch with a byte-memory model and a
//            scoreboard of expected {pc, inst} deliveries.
// Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        jump_i = 1'b0;
    logic [31:0] jump_addr_i = 32'd0;
    logic        mem_grant_i = 1'b0;
    logic [7:0]  mem_din_i = 8'd0;
    logic [31:0] mem_a_o;
    logic        mem_rd_o;
    logic        id_ready_i = 1'b0;
    logic        if_valid_o;
    logic [31:0] if_pc_o;
    logic [31:0] if_inst_o;

    if_fetch #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .jump_i      (jump_i),
        .jump_addr_i (jump_addr_i),
        .mem_grant_i (mem_grant_i),
        .mem_din_i   (mem_din_i),
        .mem_a_o     (mem_a_o),
        .mem_rd_o    (mem_rd_o),
        .id_ready_i  (id_ready_i),
        .if_valid_o  (if_valid_o),
        .if_pc_o     (if_pc_o),
        .if_inst_o   (if_inst_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] sb_q[$];

    logic        g_rst = 1'b1, g_grant = 1'b0, g_ready = 1'b0, g_jump = 1'b0;
    logic [31:0] g_jaddr = 32'd0;

    logic        o_rd, o_valid;
    logic [31:0] o_a;
    logic        p_hold = 1'b0;
    logic [31:0] p_pc, p_inst;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'h0: return 8'h13;
            32'h1: return 8'h05;
            32'h2: return 8'hA0;
            32'h3: return 8'h00;
            default: return (a[7:0] * 8'd37) ^ a[31:24] ^ 8'hC3;
        endcase
    endfunction

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
    endfunction

    task automatic sb_push(input logic [31:0] pc);
        sb_q.push_back({pc, word_at(pc)});
    endtask

    // One clock cycle: drive inputs, sample outputs, scoreboard, memory reply.
    task automatic step();
        logic        req;
        logic [31:0] ra;
        logic [63:0] e;
        @(negedge clk);
        rst = g_rst; mem_grant_i = g_grant; id_ready_i = g_ready;
        jump_i = g_jump; jump_addr_i = g_jaddr;
        #1;
        o_rd = mem_rd_o; o_a = mem_a_o; o_valid = if_valid_o;
        if (p_hold && !rst) begin
            check_eq("hold_valid", {31'd0, if_valid_o}, 32'd1);
            check_eq("hold_pc", if_pc_o, p_pc);
            check_eq("hold_inst", if_inst_o, p_inst);
        end
        if (if_valid_o && id_ready_i && !jump_i && !rst) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_unexpected", if_pc_o, 32'hDEAD_BEEF);
            end else begin
                e = sb_q.pop_front();
                check_eq("sb_pc", if_pc_o, e[63:32]);
                check_eq("sb_inst", if_inst_o, e[31:0]);
            end
        end
        req = mem_rd_o && mem_grant_i;
        ra  = mem_a_o;
        p_hold = if_valid_o && !id_ready_i && !jump_i && !rst;
        p_pc = if_pc_o; p_inst = if_inst_o;
        @(posedge clk);
        #1;
        mem_din_i = req ? mem_byte(ra) : 8'h00;
    endtask

    task automatic wait_valid(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (o_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check_eq(tag, {31'd0, seen}, 32'd1);
    endtask

    initial begin
        // Reset state
        g_rst = 1'b1; g_grant = 1'b1; g_ready = 1'b1;
        step(); step();
        check_eq("rst_rd", {31'd0, o_rd}, 32'd0);
        check_eq("rst_a", o_a, 32'h0);
        check_eq("rst_valid", {31'd0, o_valid}, 32'd0);
        check_eq("rst_pc", if_pc_o, 32'h0);
        check_eq("rst_inst", if_inst_o, 32'h0);

        // Basic fetch with continuous grant
        g_rst = 1'b0;
        sb_push(32'h0);
        for (int k = 0; k < 4; k++) begin
            step();
            check_eq("basic_rd", {31'd0, o_rd}, 32'd1);
            check_eq("basic_a", o_a, 32'(k));
        end
        step();
        check_eq("basic_c4_rd", {31'd0, o_rd}, 32'd0);
        check_eq("basic_c4_valid", {31'd0, o_valid}, 32'd0);
        step();
        check_eq("basic_c5_valid", {31'd0, o_valid}, 32'd1);
        check_eq("basic_c5_inst", if_inst_o, 32'h00A0_0513);
        step();
        check_eq("basic_c6_rd", {31'd0, o_rd}, 32'd1);
        check_eq("basic_c6_a", o_a, 32'h4);

        // Grant stalls on byte 1 and byte 2
        sb_push(32'h4);
        g_grant = 1'b0; step(); check_eq("gs_a5_hold", o_a, 32'h5);
        g_grant = 1'b1; step(); check_eq("gs_a5", o_a, 32'h5);
        g_grant = 1'b0; step(); check_eq("gs_a6_hold", o_a, 32'h6);
        g_grant = 1'b1; step(); check_eq("gs_a6", o_a, 32'h6);
        step(); check_eq("gs_a7", o_a, 32'h7);
        step(); check_eq("gs_c6_valid", {31'd0, o_valid}, 32'd0);
        step(); check_eq("gs_c7_valid", {31'd0, o_valid}, 32'd1);

        // Redirect in the same cycle as the accept of pc 0x8
        g_ready = 1'b0;
        wait_valid("ja_wait_valid");
        check_eq("ja_pc8", if_pc_o, 32'h8);
        g_ready = 1'b1; g_jump = 1'b1; g_jaddr = 32'h40;
        step();
        g_jump = 1'b0;
        step();
        check_eq("ja_valid_low", {31'd0, o_valid}, 32'd0);
        check_eq("ja_a", o_a, 32'h40);

        // Decode stall on pc 0x40
        sb_push(32'h40);
        g_ready = 1'b0;
        wait_valid("ds_wait_valid");
        for (int k = 0; k < 6; k++) begin
            step();
            check_eq("ds_valid", {31'd0, o_valid}, 32'd1);
            check_eq("ds_rd", {31'd0, o_rd}, 32'd0);
        end
        g_ready = 1'b1;
        step();
        step();
        check_eq("ds_next_a", o_a, 32'h44);

        // Redirect mid-fetch during the byte-2 issue
        step(); check_eq("rm_a45", o_a, 32'h45);
        g_jump = 1'b1; g_jaddr = 32'h100;
        step(); check_eq("rm_a46", o_a, 32'h46);
        g_jump = 1'b0;
        step();
        check_eq("rm_a100", o_a, 32'h100);
        sb_push(32'h100);
        wait_valid("rm_wait_valid");

        // PC wrap at the top of the address space
        g_jump = 1'b1; g_jaddr = 32'hFFFF_FFFC;
        step();
        g_jump = 1'b0;
        sb_push(32'hFFFF_FFFC);
        wait_valid("wr_wait_valid");
        step();
        check_eq("wr_a0", o_a, 32'h0);
        sb_push(32'h0);
        wait_valid("wr_wait_valid2");

        // Reset mid-fetch
        step(); step();
        check_eq("rr_pre_a", o_a, 32'h5);
        g_rst = 1'b1;
        step();
        check_eq("rr_rd", {31'd0, o_rd}, 32'd0);
        check_eq("rr_valid", {31'd0, o_valid}, 32'd0);
        g_rst = 1'b0;
        step();
        check_eq("rr_restart_a", o_a, 32'h0);
        check_eq("rr_restart_rd", {31'd0, o_rd}, 32'd1);
        sb_push(32'h0);
        wait_valid("rr_wait_valid");
        step();

        check_eq("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
